// File: rtl/serial_regbank_loader_pkg.sv
// rtl/serial_regbank_loader_pkg.sv - shared types and helpers for the serial register bank loader
package serial_regbank_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FULL,
    COMMIT
  } state_t;

  // Address field is never narrower than one bit, even for a single-entry bank
  function automatic int addr_w_of(input int num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

endpackage

// File: rtl/serial_regbank_loader_if.sv
// rtl/serial_regbank_loader_if.sv - serial frame input and write/error status bundle
interface serial_regbank_loader_if #(
  parameter int ADDR_W = 2
);

  logic              bit_in;
  logic              bit_valid;
  logic              store;
  logic              wr_done;
  logic [ADDR_W-1:0] wr_addr;
  logic              frame_err;

  modport master (
    output bit_in, bit_valid, store,
    input  wr_done, wr_addr, frame_err
  );

  modport slave (
    input  bit_in, bit_valid, store,
    output wr_done, wr_addr, frame_err
  );

endinterface

// File: rtl/serial_regbank_loader_shifter.sv
// rtl/serial_regbank_loader_shifter.sv - frame shift register with saturating bit counter
module frame_shifter #(
  parameter int FRAME_LEN = 10,
  parameter int CNT_W     = $clog2(FRAME_LEN + 2)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 shift_en,
  input  logic                 clr,
  input  logic                 bit_in,
  output logic [FRAME_LEN-1:0] shift,
  output logic [CNT_W-1:0]     count
);

  logic [FRAME_LEN-1:0] shift_next;

  generate
    if (FRAME_LEN == 1) begin : g_single
      assign shift_next = bit_in;
    end else begin : g_multi
      assign shift_next = {shift[FRAME_LEN-2:0], bit_in};
    end
  endgenerate

  // Once the frame is full, extra bits only mark overrun; contents stay frozen
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift <= '0;
      count <= '0;
    end else if (clr) begin
      shift <= '0;
      count <= '0;
    end else if (shift_en) begin
      if (count < CNT_W'(FRAME_LEN)) begin
        shift <= shift_next;
        count <= count + CNT_W'(1);
      end else begin
        count <= CNT_W'(FRAME_LEN + 1);
      end
    end
  end

endmodule

// File: rtl/serial_regbank_loader.sv
// rtl/serial_regbank_loader.sv - addressed serial frame loader committing into a register bank
module serial_regbank_loader
  import serial_regbank_pkg::*;
#(
  parameter int  WIDTH     = 8,
  parameter int  NUM_REGS  = 4,
  parameter int  ERR_CNT_W = 4,
  localparam int ADDR_W    = addr_w_of(NUM_REGS),
  localparam int FRAME_LEN = ADDR_W + WIDTH,
  localparam int CNT_W     = $clog2(FRAME_LEN + 2)
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_regbank_loader_if.slave sif,
  input  logic [ADDR_W-1:0]     disp_sel,
  output logic [WIDTH-1:0]      led,
  output logic [FRAME_LEN-1:0]  current_shift,
  output logic [CNT_W-1:0]      bit_count,
  output logic [ERR_CNT_W-1:0]  err_count
);

  state_t            state, state_next;
  logic              shift_en;
  logic              clr;
  logic              accept;
  logic              reject;
  logic              addr_ok;
  logic [ADDR_W-1:0] addr_field;
  logic [WIDTH-1:0]  data_field;
  logic [ADDR_W-1:0] wr_addr_q;
  logic              frame_err_q;
  logic [WIDTH-1:0]  regs [NUM_REGS];

  frame_shifter #(
    .FRAME_LEN (FRAME_LEN),
    .CNT_W     (CNT_W)
  ) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .clr      (clr),
    .bit_in   (sif.bit_in),
    .shift    (current_shift),
    .count    (bit_count)
  );

  assign addr_field = current_shift[FRAME_LEN-1:WIDTH];
  assign data_field = current_shift[WIDTH-1:0];
  assign addr_ok    = int'(addr_field) < NUM_REGS;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Store outranks bit_valid on the same edge; COMMIT ignores both
  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    clr        = 1'b0;
    accept     = 1'b0;
    reject     = 1'b0;
    case (state)
      COMMIT: begin
        clr        = 1'b1;
        state_next = IDLE;
      end
      default: begin
        if (sif.store) begin
          if (state == FULL && bit_count == CNT_W'(FRAME_LEN) && addr_ok) begin
            accept     = 1'b1;
            state_next = COMMIT;
          end else begin
            reject     = 1'b1;
            clr        = 1'b1;
            state_next = IDLE;
          end
        end else if (sif.bit_valid) begin
          shift_en = 1'b1;
          if (state != FULL) begin
            state_next = (bit_count >= CNT_W'(FRAME_LEN - 1)) ? FULL : SHIFT;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr_q   <= '0;
      frame_err_q <= 1'b0;
      err_count   <= '0;
    end else begin
      frame_err_q <= reject;
      if (accept) wr_addr_q <= addr_field;
      if (reject && err_count != '1) err_count <= err_count + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (state == COMMIT) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (addr_field == ADDR_W'(i)) regs[i] <= data_field;
      end
    end
  end

  // Out-of-range selections leave the active-low LEDs dark
  always_comb begin
    led = '1;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (disp_sel == ADDR_W'(i)) led = ~regs[i];
    end
  end

  assign sif.wr_done   = (state == COMMIT);
  assign sif.wr_addr   = wr_addr_q;
  assign sif.frame_err = frame_err_q;

endmodule

// File: tb/tb_serial_regbank_loader.sv
// tb/tb_serial_regbank_loader.sv - directed bench for 4-entry and 3-entry register bank loaders
module tb_serial_regbank_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       store = 1'b0;
  logic [1:0] disp_sel = 2'd0;

  logic [7:0] led_a, led_b;
  logic [9:0] shift_a, shift_b;
  logic [3:0] cnt_a, cnt_b;
  logic [3:0] err_a, err_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_regbank_loader_if #(.ADDR_W(2)) if_a ();
  serial_regbank_loader_if #(.ADDR_W(2)) if_b ();

  assign if_a.bit_in    = bit_in;
  assign if_a.bit_valid = bit_valid;
  assign if_a.store     = store;
  assign if_b.bit_in    = bit_in;
  assign if_b.bit_valid = bit_valid;
  assign if_b.store     = store;

  serial_regbank_loader #(.WIDTH(8), .NUM_REGS(4), .ERR_CNT_W(4)) dut_a (
    .clk           (clk),
    .rst           (rst),
    .sif           (if_a),
    .disp_sel      (disp_sel),
    .led           (led_a),
    .current_shift (shift_a),
    .bit_count     (cnt_a),
    .err_count     (err_a)
  );

  serial_regbank_loader #(.WIDTH(8), .NUM_REGS(3), .ERR_CNT_W(4)) dut_b (
    .clk           (clk),
    .rst           (rst),
    .sif           (if_b),
    .disp_sel      (disp_sel),
    .led           (led_b),
    .current_shift (shift_b),
    .bit_count     (cnt_b),
    .err_count     (err_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bit_in    = v[i];
      bit_valid = 1'b1;
      tick();
    end
    bit_valid = 1'b0;
  endtask

  task automatic do_store();
    store = 1'b1;
    tick();
    store = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held through the first edge
    #7;
    check("rst_led",  32'(led_a), 32'hFF);
    check("rst_cnt",  32'(cnt_a), 32'd0);
    check("rst_err",  32'(err_a), 32'd0);
    check("rst_done", 32'(if_a.wr_done), 32'd0);
    check("rst_ferr", 32'(if_a.frame_err), 32'd0);
    #5 rst = 1'b0;
    tick();

    // Good frame: addr 2, data A5
    send_bits(16'h2A5, 10);
    check("good_cnt",   32'(cnt_a), 32'd10);
    check("good_shift", 32'(shift_a), 32'h2A5);
    disp_sel = 2'd2;
    do_store();
    check("good_done",     32'(if_a.wr_done), 32'd1);
    check("good_addr",     32'(if_a.wr_addr), 32'd2);
    check("good_led_lat",  32'(led_a), 32'hFF);
    tick();
    check("good_done_end", 32'(if_a.wr_done), 32'd0);
    check("good_led",      32'(led_a), 32'h5A);
    check("good_led_b",    32'(led_b), 32'h5A);
    check("good_cnt_clr",  32'(cnt_a), 32'd0);
    disp_sel = 2'd0; #1;
    check("other_reg0", 32'(led_a), 32'hFF);
    disp_sel = 2'd1; #1;
    check("other_reg1", 32'(led_a), 32'hFF);

    // Short frame rejected
    send_bits(16'h0F0, 9);
    check("short_cnt", 32'(cnt_a), 32'd9);
    do_store();
    check("short_ferr",  32'(if_a.frame_err), 32'd1);
    check("short_err",   32'(err_a), 32'd1);
    check("short_cnt0",  32'(cnt_a), 32'd0);
    check("short_nodone", 32'(if_a.wr_done), 32'd0);
    tick();
    check("short_ferr_end", 32'(if_a.frame_err), 32'd0);
    check("short_led1", 32'(led_a), 32'hFF);

    // Following good frame: addr 1, data 3C
    send_bits(16'h13C, 10);
    do_store();
    check("next_addr", 32'(if_a.wr_addr), 32'd1);
    tick();
    check("next_led1", 32'(led_a), 32'hC3);
    disp_sel = 2'd2; #1;
    check("next_led2", 32'(led_a), 32'h5A);

    // Address 3: valid for 4 regs, out of range for 3 regs
    send_bits(16'h381, 10);
    do_store();
    check("a3_done_a", 32'(if_a.wr_done), 32'd1);
    check("a3_done_b", 32'(if_b.wr_done), 32'd0);
    check("a3_ferr_b", 32'(if_b.frame_err), 32'd1);
    check("a3_err_b",  32'(err_b), 32'd2);
    tick();
    disp_sel = 2'd3; #1;
    check("a3_led_a", 32'(led_a), 32'h7E);
    check("a3_led_b", 32'(led_b), 32'hFF);

    // Store on the same edge as the 10th bit: bit dropped, reject
    send_bits(16'h155, 9);
    bit_in = 1'b1; bit_valid = 1'b1; store = 1'b1;
    tick();
    bit_valid = 1'b0; store = 1'b0;
    check("coll_ferr", 32'(if_a.frame_err), 32'd1);
    check("coll_done", 32'(if_a.wr_done), 32'd0);
    check("coll_cnt",  32'(cnt_a), 32'd0);
    check("coll_err",  32'(err_a), 32'd2);
    tick();

    // Overrun: 11 bits then store, repeated until saturation
    send_bits(16'h5A5, 11);
    check("ovr_cnt",   32'(cnt_a), 32'd11);
    check("ovr_shift", 32'(shift_a), 32'h2D2);
    do_store();
    check("ovr_ferr", 32'(if_a.frame_err), 32'd1);
    check("ovr_err1", 32'(err_a), 32'd3);
    for (int r = 1; r < 20; r++) begin
      send_bits(16'h5A5, 11);
      do_store();
    end
    check("ovr_sat_a", 32'(err_a), 32'd15);
    check("ovr_sat_b", 32'(err_b), 32'd15);
    disp_sel = 2'd1; #1;
    check("ovr_led1", 32'(led_a), 32'hC3);

    // Reset asserted mid-cycle during COMMIT aborts the write
    disp_sel = 2'd0;
    send_bits(16'h077, 10);
    do_store();
    check("rc_done", 32'(if_a.wr_done), 32'd1);
    #3 rst = 1'b1;
    #1;
    check("rc_led0",  32'(led_a), 32'hFF);
    check("rc_err",   32'(err_a), 32'd0);
    check("rc_cnt",   32'(cnt_a), 32'd0);
    check("rc_done0", 32'(if_a.wr_done), 32'd0);
    #2 rst = 1'b0;
    tick();
    check("rc_led0_after", 32'(led_a), 32'hFF);
    check("rc_done_after", 32'(if_a.wr_done), 32'd0);
    disp_sel = 2'd1; #1;
    check("rc_led1_clr", 32'(led_a), 32'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
